knn_sorted_list: RTL and testbench
==================================

Name: knn_sorted_list

Overview:
- Parametrised successor to the single-entry nearest-neighbour register. Keeps a K-deep list of (distance, label) pairs, sorted ascending by distance, so entry 0 is always the nearest neighbour.
- Accepts one candidate per cycle through a valid/ready handshake. Framed by start and last into one query.
- Sits between the distance datapath and the label-vote/control block of the KNN accelerator.

Parameters:
- DATA_W, 32, distance width (unsigned)
- LABEL_W, 8, label width
- K, 4, list depth (number of neighbours kept); legal range 1..16
- CNT_W, $clog2(K+1), width of count output

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse: clear list and open a new query
- in_valid  in  1  candidate present
- in_ready  out  1  block can accept a candidate
- in_last  in  1  qualifies in_valid: final candidate of the query
- dist_in  in  DATA_W  candidate distance
- label_in  in  LABEL_W  candidate label
- nn_dist  out  K*DATA_W  sorted distances; entry i at bits [i*DATA_W +: DATA_W]
- nn_label  out  K*LABEL_W  labels matching nn_dist
- nn_valid  out  K  per-entry valid, thermometer-coded from bit 0
- count  out  CNT_W  number of valid entries, saturates at K
- worst_dist  out  DATA_W  distance of entry K-1 if valid, else all-ones
- done  out  1  query complete, list frozen

Behaviour:
- Reset (rst=0, asynchronous) forces the following; no other output changes during reset:
  - state = IDLE
  - nn_dist = 0, nn_label = 0, nn_valid = 0, count = 0
  - worst_dist = all-ones, done = 0, in_ready = 0
- State machine (3 states: IDLE, FILL, DONE):
  - IDLE: in_ready=0, done=0. start → FILL.
  - FILL: in_ready=1, done=0. Accepted beat (in_valid & in_ready) with in_last=1 → DONE, otherwise stay in FILL.
  - DONE: in_ready=0, done=1, list held. start → FILL.
- Any start, in any state, on its clock edge:
  - clears nn_valid, count, nn_dist and nn_label to 0;
  - enters FILL.
  - A beat presented in the same cycle as start is not accepted (in_ready is held 0 that cycle, combinationally from start).
- Insertion on an accepted beat:
  - Compare is unsigned. Invalid entries count as +infinity.
  - p = number of valid entries with dist <= dist_in. Ties insert after existing equal entries, so ordering is stable.
  - If p < K: entries p..K-2 shift to p+1..K-1, the old entry K-1 is dropped, and entry p takes (dist_in, label_in).
  - If p = K (list full and dist_in >= worst_dist): candidate is discarded and the list is unchanged.
  - count increments on insertion while below K.
- Latency and throughput:
  - Updated list, count and worst_dist are visible the cycle after the accepting edge.
  - Throughput is 1 candidate per cycle; no bubbles in FILL.
- The in_last beat is inserted under the same rules as any other beat. done rises the cycle after it is accepted.
- Boundary conditions:
  - in_valid in IDLE or DONE is ignored; in_ready=0 there.
  - dist_in = all-ones into an empty slot is inserted, and that entry becomes valid.
  - K=1 degenerates to a min-register with valid and handshake.
- Comparison is a parallel K-way compare followed by a one-hot/thermometer shift; no multi-cycle sort.

Test Plan:
- Reset with rst=0 mid-FILL holding 3 entries → all outputs return to reset values immediately, without waiting for clk; after rst=1, in_ready=0 until start.
- K=4, start, then beats dist 50,20,80,10 (labels 1,2,3,4), last on 10 → nn_dist=[10,20,50,80], nn_label=[4,2,1,3], count=4, done=1 the next cycle.
- Full list [10,20,50,80]: beat 30 → [10,20,30,50] with 80 dropped, worst_dist=50. Then beat 60 → discarded, list unchanged.
- Ties: beats 20(label 7) then 20(label 9) → entry0 label 7, entry1 label 9. A third beat of 20 with K=2 → discarded.
- Handshake: start asserted together with in_valid=1 → beat not accepted, count stays 0. In DONE, in_valid=1 with dist 1 → ignored; start then clears the list and returns to FILL.
- Partial fill: 2 beats 5,3, last on 3 → nn_valid=4'b0011, count=2, worst_dist=all-ones, done=1.

Source files
------------

// File: rtl/knn_sorted_list.sv
// K-deep nearest-neighbour list kept sorted ascending by distance; one candidate per cycle.
// Insertion uses a parallel compare to find the slot, then shifts the tail down by one entry.
module knn_sorted_list #(
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 8,
  parameter int K       = 4,
  parameter int CNT_W   = $clog2(K+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [DATA_W-1:0]    dist_in,
  input  logic [LABEL_W-1:0]   label_in,
  output logic [K*DATA_W-1:0]  nn_dist,
  output logic [K*LABEL_W-1:0] nn_label,
  output logic [K-1:0]         nn_valid,
  output logic [CNT_W-1:0]     count,
  output logic [DATA_W-1:0]    worst_dist,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DONE = 2'd2} state_t;

  state_t             state_r;
  logic               done_r;
  logic [CNT_W-1:0]   count_r;
  logic [DATA_W-1:0]  worst_r;
  logic [K-1:0]       le_s;
  logic               accept_s;
  logic               insert_s;
  logic [DATA_W-1:0]  last_dist_nx_s;
  logic               last_valid_nx_s;

  assign in_ready = (state_r == FILL) && !start;
  assign accept_s = in_valid && in_ready;
  // Every slot holds a distance <= candidate exactly when the list is full and it loses.
  assign insert_s = accept_s && !le_s[K-1];

  for (genvar i = 0; i < K; i++) begin : g_slot
    logic [DATA_W-1:0]  dist_r;
    logic [LABEL_W-1:0] label_r;
    logic               valid_r;
    logic               front_s;
    logic [DATA_W-1:0]  prev_dist_s;
    logic [LABEL_W-1:0] prev_label_s;
    logic               prev_valid_s;
    logic [DATA_W-1:0]  dist_nx_s;
    logic [LABEL_W-1:0] label_nx_s;
    logic               valid_nx_s;

    if (i == 0) begin : g_head
      assign front_s      = 1'b1;
      assign prev_dist_s  = {DATA_W{1'b0}};
      assign prev_label_s = {LABEL_W{1'b0}};
      assign prev_valid_s = 1'b0;
    end else begin : g_tail
      assign front_s      = le_s[i-1];
      assign prev_dist_s  = g_slot[i-1].dist_r;
      assign prev_label_s = g_slot[i-1].label_r;
      assign prev_valid_s = g_slot[i-1].valid_r;
    end

    // Thermometer: slots before the insertion point keep, the first other slot takes the candidate.
    assign le_s[i]    = valid_r && (dist_r <= dist_in);
    assign dist_nx_s  = le_s[i] ? dist_r  : (front_s ? dist_in  : prev_dist_s);
    assign label_nx_s = le_s[i] ? label_r : (front_s ? label_in : prev_label_s);
    assign valid_nx_s = le_s[i] ? valid_r : (front_s ? 1'b1     : prev_valid_s);

    // Slot register: cleared by start, loaded with its shifted/inserted value on insertion
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dist_r  <= {DATA_W{1'b0}};
        label_r <= {LABEL_W{1'b0}};
        valid_r <= 1'b0;
      end else if (start) begin
        dist_r  <= {DATA_W{1'b0}};
        label_r <= {LABEL_W{1'b0}};
        valid_r <= 1'b0;
      end else if (insert_s) begin
        dist_r  <= dist_nx_s;
        label_r <= label_nx_s;
        valid_r <= valid_nx_s;
      end else begin
        dist_r  <= dist_r;
        label_r <= label_r;
        valid_r <= valid_r;
      end
    end

    if (i == K-1) begin : g_last
      assign last_dist_nx_s  = dist_nx_s;
      assign last_valid_nx_s = valid_nx_s;
    end

    assign nn_dist[i*DATA_W +: DATA_W]    = dist_r;
    assign nn_label[i*LABEL_W +: LABEL_W] = label_r;
    assign nn_valid[i]                    = valid_r;
  end

  // Query control FSM with registered done, count and worst distance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      done_r  <= 1'b0;
      count_r <= {CNT_W{1'b0}};
      worst_r <= {DATA_W{1'b1}};
    end else if (start) begin
      state_r <= FILL;
      done_r  <= 1'b0;
      count_r <= {CNT_W{1'b0}};
      worst_r <= {DATA_W{1'b1}};
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
        FILL: begin
          if (insert_s) begin
            worst_r <= last_valid_nx_s ? last_dist_nx_s : {DATA_W{1'b1}};
            if (count_r < CNT_W'(K)) begin
              count_r <= count_r + CNT_W'(1);
            end else begin
              count_r <= count_r;
            end
          end else begin
            worst_r <= worst_r;
          end
          if (accept_s && in_last) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= FILL;
            done_r  <= 1'b0;
          end
        end
        DONE: begin
          state_r <= DONE;
          done_r  <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign count      = count_r;
  assign worst_dist = worst_r;
  assign done       = done_r;

endmodule

// File: tb/tb_knn_sorted_list.sv
// Bench for knn_sorted_list: K=4 and K=2 instances on shared inputs, checked every cycle
// against a queue-based sorted-list model, with directed cases followed by random queries.
module tb_knn_sorted_list;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_last;
  logic [31:0] dist_in;
  logic [7:0]  label_in;

  logic         a_ready, a_done;
  logic [127:0] a_dist;
  logic [31:0]  a_label;
  logic [3:0]   a_valid;
  logic [2:0]   a_count;
  logic [31:0]  a_worst;

  logic         b_ready, b_done;
  logic [63:0]  b_dist;
  logic [15:0]  b_label;
  logic [1:0]   b_valid;
  logic [1:0]   b_count;
  logic [31:0]  b_worst;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  l;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  bit   m_fill = 1'b0;
  bit   m_done = 1'b0;

  always #5 clk = ~clk;

  knn_sorted_list #(.DATA_W(32), .LABEL_W(8), .K(4)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(a_ready),
    .in_last(in_last), .dist_in(dist_in), .label_in(label_in), .nn_dist(a_dist),
    .nn_label(a_label), .nn_valid(a_valid), .count(a_count), .worst_dist(a_worst), .done(a_done)
  );

  knn_sorted_list #(.DATA_W(32), .LABEL_W(8), .K(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(b_ready),
    .in_last(in_last), .dist_in(dist_in), .label_in(label_in), .nn_dist(b_dist),
    .nn_label(b_label), .nn_valid(b_valid), .count(b_count), .worst_dist(b_worst), .done(b_done)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Number of stored entries with distance <= d: the stable insertion position.
  function automatic int ins_pos(input ent_t q[$], input logic [31:0] d);
    int p = 0;
    foreach (q[i]) if (q[i].d <= d) p++;
    return p;
  endfunction

  function automatic logic [255:0] exp_dist(input ent_t q[$]);
    logic [255:0] r = '0;
    foreach (q[i]) r[i*32 +: 32] = q[i].d;
    return r;
  endfunction

  function automatic logic [255:0] exp_label(input ent_t q[$]);
    logic [255:0] r = '0;
    foreach (q[i]) r[i*8 +: 8] = q[i].l;
    return r;
  endfunction

  function automatic logic [255:0] exp_valid(input ent_t q[$]);
    logic [255:0] r = '0;
    foreach (q[i]) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [255:0] exp_worst(input ent_t q[$], input int k);
    if (q.size() == k) return {224'd0, q[k-1].d};
    return {224'd0, 32'hFFFF_FFFF};
  endfunction

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_fill = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit v, input bit l,
                            input logic [31:0] d, input logic [7:0] lab);
    ent_t e;
    int   p;
    e.d = d;
    e.l = lab;
    if (s) begin
      qa.delete();
      qb.delete();
      m_fill = 1'b1;
      m_done = 1'b0;
    end else if (m_fill && v) begin
      p = ins_pos(qa, d);
      if (p < 4) begin
        qa.insert(p, e);
        if (qa.size() > 4) void'(qa.pop_back());
      end
      p = ins_pos(qb, d);
      if (p < 2) begin
        qb.insert(p, e);
        if (qb.size() > 2) void'(qb.pop_back());
      end
      if (l) begin
        m_fill = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    check("a_dist",  a_dist,  exp_dist(qa));
    check("a_label", a_label, exp_label(qa));
    check("a_valid", a_valid, exp_valid(qa));
    check("a_count", a_count, qa.size());
    check("a_worst", a_worst, exp_worst(qa, 4));
    check("a_done",  a_done,  m_done);
    check("b_dist",  b_dist,  exp_dist(qb));
    check("b_label", b_label, exp_label(qb));
    check("b_valid", b_valid, exp_valid(qb));
    check("b_count", b_count, qb.size());
    check("b_worst", b_worst, exp_worst(qb, 2));
    check("b_done",  b_done,  m_done);
  endtask

  task automatic cycle(input bit s, input bit v, input bit l,
                       input logic [31:0] d, input logic [7:0] lab);
    start    = s;
    in_valid = v;
    in_last  = l;
    dist_in  = d;
    label_in = lab;
    #1;
    check("a_ready", a_ready, m_fill && !s);
    check("b_ready", b_ready, m_fill && !s);
    @(posedge clk);
    model_step(s, v, l, d, lab);
    #1;
    check_all();
  endtask

  task automatic beat(input logic [31:0] d, input logic [7:0] lab, input bit l);
    cycle(1'b0, 1'b1, l, d, lab);
  endtask

  task automatic do_start();
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 8'd0);
  endtask

  logic [31:0] rd;
  int          nbeats;

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    dist_in = 32'd0; label_in = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, 32'd3, 8'd3);

    // Basic sorted fill, last on the smallest distance
    do_start();
    beat(32'd50, 8'd1, 1'b0);
    beat(32'd20, 8'd2, 1'b0);
    beat(32'd80, 8'd3, 1'b0);
    beat(32'd10, 8'd4, 1'b1);
    check("sorted_dist",  a_dist,  {32'd80, 32'd50, 32'd20, 32'd10});
    check("sorted_label", a_label, {8'd3, 8'd1, 8'd2, 8'd4});
    check("sorted_done",  a_done,  1'b1);

    // Beat in DONE ignored; start with a beat in the same cycle is not accepted
    beat(32'd1, 8'd5, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'd7, 8'd7);
    check("start_beat_cnt", a_count, 3'd0);

    // Full list: 30 displaces 80, 60 is discarded
    beat(32'd50, 8'd1, 1'b0);
    beat(32'd20, 8'd2, 1'b0);
    beat(32'd80, 8'd3, 1'b0);
    beat(32'd10, 8'd4, 1'b0);
    beat(32'd30, 8'd6, 1'b0);
    check("drop_dist",  a_dist,  {32'd50, 32'd30, 32'd20, 32'd10});
    check("drop_worst", a_worst, 32'd50);
    beat(32'd60, 8'd8, 1'b1);
    check("discard_dist", a_dist, {32'd50, 32'd30, 32'd20, 32'd10});

    // Ties stay in arrival order; third equal beat is discarded by the K=2 list
    do_start();
    beat(32'd20, 8'd7, 1'b0);
    beat(32'd20, 8'd9, 1'b0);
    beat(32'd20, 8'd11, 1'b1);
    check("tie_label_k2", b_label, {8'd9, 8'd7});

    // Partial fill
    do_start();
    beat(32'd5, 8'd1, 1'b0);
    beat(32'd3, 8'd2, 1'b1);
    check("part_valid", a_valid, 4'b0011);
    check("part_worst", a_worst, 32'hFFFF_FFFF);

    // All-ones distance into an empty list still becomes valid
    do_start();
    beat(32'hFFFF_FFFF, 8'd9, 1'b1);
    check("ones_valid", a_valid, 4'b0001);

    // Asynchronous reset mid-fill with three entries
    do_start();
    beat(32'd4, 8'd1, 1'b0);
    beat(32'd8, 8'd2, 1'b0);
    beat(32'd2, 8'd3, 1'b0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, 32'd1, 8'd1);

    // Random queries
    for (int q = 0; q < 40; q++) begin
      do_start();
      nbeats = $urandom_range(1, 12);
      for (int b = 0; b < nbeats; b++) begin
        case ($urandom_range(0, 3))
          0:       rd = 32'hFFFF_FFFF;
          1:       rd = $urandom;
          default: rd = $urandom_range(0, 15);
        endcase
        cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
              (b == nbeats - 1), rd, 8'($urandom));
      end
      cycle(1'b0, 1'b1, 1'b0, 32'd0, 8'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
